multicycle_control_fsm: RTL

Main control state machine of the 32-bit multicycle CPU. Sits directly upstream of myALU: decodes opcode/funct from the instruction register, sequences each instruction through fetch/decode/execute/memory/writeback, and drives ALUSel, the ALU operand-source selects, and every datapath strobe. It also consumes the ALU `zero` flag to resolve BEQ. The memory interface is handshaked with `mem_ready` so that multi-cycle memories stall the sequence.

---
 rtl/multicycle_control_fsm_if.sv | 38 +++
 rtl/multicycle_control_fsm.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// Master is the FSM; slave is the datapath side that supplies decode/flags.
interface multicycle_control_fsm_if #(
    parameter int OP_WIDTH = 6
);
    logic [OP_WIDTH-1:0] opcode;
    logic [OP_WIDTH-1:0] funct;
    logic                zero;
    logic                mem_ready;
    logic [3:0]          ALUSel;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic                pc_write;
    logic [1:0]          pc_source;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                illegal;
    logic [3:0]          state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output ALUSel, alu_src_a, alu_src_b, pc_write, pc_source,
        output i_or_d, mem_read, mem_write, ir_write, reg_write,
        output reg_dst, mem_to_reg, illegal, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  ALUSel, alu_src_a, alu_src_b, pc_write, pc_source,
        input  i_or_d, mem_read, mem_write, ir_write, reg_write,
        input  reg_dst, mem_to_reg, illegal, state
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the 32-bit multicycle CPU: sequences each
// instruction and drives ALU selects and datapath strobes.
module multicycle_control_fsm #(
    parameter int OP_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_control_fsm_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_EXEC_I    = 4'd10,
        S_I_WB      = 4'd11
    } state_e;

    localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(6'h00);
    localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'h23);
    localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'h2B);
    localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'h04);
    localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'h02);
    localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'h08);
    localparam logic [OP_WIDTH-1:0] FN_ADD  = OP_WIDTH'(6'h20);
    localparam logic [OP_WIDTH-1:0] FN_SUB  = OP_WIDTH'(6'h22);
    localparam logic [OP_WIDTH-1:0] FN_AND  = OP_WIDTH'(6'h24);
    localparam logic [OP_WIDTH-1:0] FN_OR   = OP_WIDTH'(6'h25);
    localparam logic [OP_WIDTH-1:0] FN_SLT  = OP_WIDTH'(6'h2A);

    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    state_e     state_q;
    state_e     state_d;
    logic [3:0] alu_sel;
    logic       src_a;
    logic [1:0] src_b;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rwr;
    logic       rdst;
    logic       m2r;
    logic       ill;

    always_comb begin
        state_d = S_FETCH;
        alu_sel = ALU_ADD;
        src_a   = 1'b0;
        src_b   = 2'b00;
        pc_wr   = 1'b0;
        pc_src  = 2'b00;
        iord    = 1'b0;
        mrd     = 1'b0;
        mwr     = 1'b0;
        irw     = 1'b0;
        rwr     = 1'b0;
        rdst    = 1'b0;
        m2r     = 1'b0;
        ill     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mrd     = 1'b1;
                src_b   = 2'b01;
                irw     = bus.mem_ready;
                pc_wr   = bus.mem_ready;
                state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                src_b = 2'b11;
                case (bus.opcode)
                    OP_R:         state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_EXEC_I;
                    default: begin
                        ill     = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                src_a   = 1'b1;
                src_b   = 2'b10;
                state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mrd     = 1'b1;
                iord    = 1'b1;
                state_d = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                rwr = 1'b1;
                m2r = 1'b1;
            end
            S_MEM_WRITE: begin
                mwr     = 1'b1;
                iord    = 1'b1;
                state_d = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXEC_R: begin
                src_a   = 1'b1;
                state_d = S_R_WB;
                case (bus.funct)
                    FN_ADD:  alu_sel = ALU_ADD;
                    FN_SUB:  alu_sel = ALU_SUB;
                    FN_AND:  alu_sel = ALU_AND;
                    FN_OR:   alu_sel = ALU_OR;
                    FN_SLT:  alu_sel = ALU_SLT;
                    default: begin
                        ill     = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_R_WB: begin
                rwr  = 1'b1;
                rdst = 1'b1;
            end
            S_BRANCH: begin
                src_a   = 1'b1;
                alu_sel = ALU_SUB;
                pc_src  = 2'b01;
                pc_wr   = bus.zero;
            end
            S_JUMP: begin
                pc_wr  = 1'b1;
                pc_src = 2'b10;
            end
            S_EXEC_I: begin
                src_a   = 1'b1;
                src_b   = 2'b10;
                state_d = S_I_WB;
            end
            S_I_WB: begin
                rwr = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes are masked during reset since FETCH would otherwise read.
    assign bus.ALUSel     = alu_sel;
    assign bus.alu_src_a  = src_a;
    assign bus.alu_src_b  = src_b;
    assign bus.pc_source  = pc_src;
    assign bus.i_or_d     = iord;
    assign bus.reg_dst    = rdst;
    assign bus.mem_to_reg = m2r;
    assign bus.pc_write   = pc_wr & rst_n;
    assign bus.ir_write   = irw & rst_n;
    assign bus.mem_read   = mrd & rst_n;
    assign bus.mem_write  = mwr & rst_n;
    assign bus.reg_write  = rwr & rst_n;
    assign bus.illegal    = ill & rst_n;
    assign bus.state      = state_q;
endmodule
